// File: rtl/simple_tx_arbiter.sv
// rtl/simple_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among FWFT requester FIFOs
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   i_din       requester head words, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   i_empty     requester FIFO empty flags
//   o_re        requester pop strobes (one-hot or zero)
//   o_dout      word offered to the transmitter
//   o_tx_empty  high when no word is offered
//   i_tx_re     transmitter consumes o_dout this cycle
//   o_grant     one-hot granted channel, zero when idle
//   o_busy      high in any state other than IDLE
module simple_tx_arbiter #(
    parameter int                    NUM_CHANNELS  = 4,
    parameter int                    WORD_WIDTH    = 8,
    parameter int                    MAX_BURST     = 16,
    parameter bit                    HEADER_ENABLE = 1'b1,
    parameter logic [WORD_WIDTH-1:0] HEADER_BASE   = WORD_WIDTH'(8'hF0)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] i_din,
    input  logic [NUM_CHANNELS-1:0]            i_empty,
    output logic [NUM_CHANNELS-1:0]            o_re,
    output logic [WORD_WIDTH-1:0]              o_dout,
    output logic                               o_tx_empty,
    input  logic                               i_tx_re,
    output logic [NUM_CHANNELS-1:0]            o_grant,
    output logic                               o_busy
);

    localparam int IDX_W = $clog2(NUM_CHANNELS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [IDX_W-1:0] r_g;
    logic [IDX_W-1:0] w_g_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic                  w_found;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_sel_empty;
    logic [WORD_WIDTH-1:0] w_sel_din;
    logic                  w_pop;

    assign w_sel_empty = i_empty[r_g];
    assign w_sel_din   = i_din[r_g*WORD_WIDTH +: WORD_WIDTH];
    assign w_pop       = (r_state == S_DATA) && i_tx_re && !w_sel_empty;

    // Round-robin search starting just after the last served channel.
    // Iterating from the farthest candidate back to the nearest lets the
    // nearest non-empty channel overwrite any earlier match.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            if (!i_empty[IDX_W'((int'(r_last) + k) % NUM_CHANNELS)]) begin
                w_found = 1'b1;
                w_cand  = IDX_W'((int'(r_last) + k) % NUM_CHANNELS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= IDX_W'(NUM_CHANNELS - 1);
            r_g     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_g     <= w_g_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_g_nxt     = r_g;
        w_cnt_nxt   = r_cnt;
        o_re        = '0;
        o_dout      = '0;
        o_tx_empty  = 1'b1;
        o_grant     = '0;
        o_busy      = (r_state != S_IDLE);

        if (r_state != S_IDLE) begin
            o_grant[r_g] = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_g_nxt     = w_cand;
                    w_cnt_nxt   = '0;
                    w_state_nxt = HEADER_ENABLE ? S_HEADER : S_DATA;
                end
            end
            S_HEADER: begin
                o_dout     = HEADER_BASE + WORD_WIDTH'(r_g);
                o_tx_empty = 1'b0;
                if (i_tx_re) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                o_dout     = w_sel_din;
                o_tx_empty = w_sel_empty;
                o_re[r_g]  = w_pop;
                if (w_pop) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_RELEASE;
                    end
                end else if (w_sel_empty) begin
                    // Only this arbiter pops, so empty here means drained.
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_last_nxt  = r_g;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/simple_tx_arbiter.md
# simple_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_CHANNELS` requester FIFOs. Each requester FIFO is first-word-fall-through. The arbiter grants one channel at a time for a burst of up to `MAX_BURST` words, optionally preceded by a channel-ID header word. Toward the transmitter it looks like a single first-word-fall-through FIFO (`dout`/`tx_empty`/`tx_re`). It sits between the per-source TX FIFOs and the transmitter.

## Interface
- `NUM_CHANNELS`, 4, number of requesters; 2..16.
- `WORD_WIDTH`, 8, word width.
- `MAX_BURST`, 16, maximum data words per grant; ≥1.
- `HEADER_ENABLE`, 1, 1 = emit a header word before each burst.
- `HEADER_BASE`, 8'hF0, header word = `HEADER_BASE + channel index` (`WORD_WIDTH` bits, wraps modulo 2^`WORD_WIDTH`).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  `NUM_CHANNELS*WORD_WIDTH`  requester head words; channel i occupies `[i*WORD_WIDTH +: WORD_WIDTH]`.
- `empty`  in  `NUM_CHANNELS`  requester FIFO empty flags.
- `re`  out  `NUM_CHANNELS`  requester pop strobes, one-hot or zero.
- `dout`  out  `WORD_WIDTH`  word offered to the transmitter.
- `tx_empty`  out  1  high = no word offered.
- `tx_re`  in  1  transmitter consumes `dout` this cycle.
- `grant`  out  `NUM_CHANNELS`  one-hot granted channel, 0 when idle.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, HEADER, DATA, RELEASE.
- Internal registers:
  - `last`: index of the most recently served channel.
  - `g`: index of the granted channel.
  - `cnt`: words sent in the current burst, width `$clog2(MAX_BURST+1)`.
- **IDLE**
  - `tx_empty`=1, `grant`=0.
  - Search channels `last+1`, `last+2`, … modulo `NUM_CHANNELS` for the first with `empty[i]`=0.
  - If one is found: latch `g`=i, clear `cnt`, go to HEADER if `HEADER_ENABLE`, else DATA.
  - If none: stay in IDLE.
- **HEADER**
  - `dout` = `HEADER_BASE + g`, `tx_empty`=0, `re`=0.
  - On `tx_re`: go to DATA.
- **DATA**
  - `dout` = `din[g]` (combinational mux), `tx_empty` = `empty[g]`.
  - `re[g]` = `tx_re & ~empty[g]` (combinational); all other `re` bits are 0.
  - Each pop increments `cnt`.
  - Go to RELEASE when a pop occurs with `cnt == MAX_BURST-1`, or when `empty[g]`=1.
  - Only the arbiter pops, so `empty[g]`=1 here means the channel has drained.
- **RELEASE**
  - One cycle, `tx_empty`=1, `last` ← `g`, go to IDLE.
- `grant` is one-hot of `g` in HEADER, DATA and RELEASE; 0 in IDLE.
- `tx_re` while `tx_empty`=1 is ignored: no pop, no state change.
- A channel whose `empty` rises while it is not granted is never popped.
- Reset mid-burst: all state returns to reset values immediately, and the partial burst is abandoned. Words already popped stay consumed; nothing is replayed.

## Timing
- Reset values: state=IDLE, `last`=`NUM_CHANNELS-1` (channel 0 has first priority), `g`=0, `cnt`=0. Outputs: `re`=0, `dout`=0, `tx_empty`=1, `grant`=0, `busy`=0.
- Request to offered word:
  - `empty[i]` falls at cycle t; IDLE samples it at t.
  - Header is offered at t+1. With `HEADER_ENABLE`=0, the data word is offered at t+1.
- Header to data: `tx_re` at cycle h gives the data word offered at h+1.
- `re[g]` asserts in the same cycle as `tx_re`. The requester FIFO must present its next head word the following cycle.
- Burst end: after the last pop (cycle p), RELEASE occurs at p+1 and IDLE at p+2.
  - If the drain is detected via `empty`, add one cycle.
  - A subsequent request can be offered no earlier than p+3.
- Inter-burst gap: RELEASE followed by IDLE gives at least 2 cycles with `tx_empty`=1 between bursts.
- Fairness: with all channels continuously non-empty, grants rotate 0,1,2,…,N-1,0; each grant is exactly `MAX_BURST` data words.

## Test plan
- **Single channel, `HEADER_ENABLE`=1.**
  - Stimulus: ch2 holds 0x11,0x22,0x33; `tx_re` pulses whenever `tx_empty`=0.
  - Required: transmitter receives 0xF2,0x11,0x22,0x33; `re[2]` pulses 3 times; `grant`=4'b0100 during the burst; then IDLE.
- **Simultaneous requests.**
  - Stimulus: ch0 and ch3 each hold 2 words, both non-empty in the same cycle after reset.
  - Required: output order is 0xF0,a0,a1 then 0xF3,b0,b1.
- **Burst limit, `MAX_BURST`=4.**
  - Stimulus: ch1 holds 6 words, ch2 holds 1 word.
  - Required: 0xF1 + 4 words, then 0xF2 + 1 word, then 0xF1 + the remaining 2 words.
- **Header disabled.**
  - Stimulus: `HEADER_ENABLE`=0; ch0 holds 0xA5.
  - Required: 0xA5 offered one cycle after `empty[0]` falls; no header word.
- **Backpressure.**
  - Stimulus: `tx_re` held low for 10 cycles in DATA; `tx_re` pulsed while `tx_empty`=1.
  - Required: `dout` stable and `re`=0 while `tx_re` is low; no pops while `tx_empty`=1.
- **Reset mid-burst.**
  - Stimulus: `rst` asserted after 2 of 5 ch1 words.
  - Required: next cycle all outputs at reset values; the following grant goes to the lowest-index non-empty channel.
